// File: rtl/mask_gen_if.sv
// Request/response bundle for mask_gen_pipe.
// The master side issues requests and consumes results; the slave side is the generator.
interface mask_gen_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NW    = $clog2(WIDTH) + 1,
  parameter int unsigned TAG_W = 5
) ();

  logic             valid_i;
  logic             ready_o;
  logic [1:0]       mode_i;
  logic [NW-1:0]    n_i;
  logic [NW-1:0]    m_i;
  logic [TAG_W-1:0] tag_i;

  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] mask_o;
  logic [NW-1:0]    count_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, mode_i, n_i, m_i, tag_i, ready_i,
    input  ready_o, valid_o, mask_o, count_o, tag_o
  );

  modport slave (
    input  valid_i, mode_i, n_i, m_i, tag_i, ready_i,
    output ready_o, valid_o, mask_o, count_o, tag_o
  );

endinterface

// File: rtl/mask_gen_pipe.sv
// Two-stage valid/ready bit-mask generator: LSB/MSB/inverted fill and inclusive range masks,
// with popcount and a passthrough tag.
module mask_gen_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NW    = $clog2(WIDTH) + 1,
  parameter int unsigned TAG_W = 5
) (
  input logic         clk_i,
  input logic         rst_i,
  mask_gen_if.slave   io
);

  typedef enum logic [1:0] {
    ModeLsb   = 2'b00,
    ModeMsb   = 2'b01,
    ModeRange = 2'b10,
    ModeInv   = 2'b11
  } mode_e;

  localparam logic [NW-1:0] WidthN = NW'(WIDTH);
  localparam logic [NW-1:0] LastN  = NW'(WIDTH - 1);

  // Stage 1: registered request.
  logic             s1_valid_q;
  mode_e            s1_mode_q;
  logic [NW-1:0]    s1_n_q;
  logic [NW-1:0]    s1_m_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2: registered result.
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_mask_q;
  logic [NW-1:0]    s2_count_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic s1_adv, s2_adv;

  always_comb begin
    s2_adv = ~s2_valid_q | io.ready_i;
    s1_adv = ~s1_valid_q | s2_adv;
  end

  assign io.ready_o = s1_adv & ~rst_i;

  // Mask and count from stage-1 values.
  logic [NW-1:0]    n_sat, hi, lo;
  logic             rng_ok;
  logic [WIDTH-1:0] lsb_mask, msb_mask, rng_mask;
  logic [WIDTH-1:0] mask_d;
  logic [NW-1:0]    count_d;

  always_comb begin
    n_sat    = (s1_n_q > WidthN) ? WidthN : s1_n_q;
    lo       = s1_n_q;
    hi       = (s1_m_q > LastN) ? LastN : s1_m_q;
    // hi never exceeds WIDTH-1, so lo <= hi also implies lo < WIDTH.
    rng_ok   = (lo <= hi);
    lsb_mask = '0;
    msb_mask = '0;
    rng_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lsb_mask[i] = (NW'(i) < n_sat);
      msb_mask[i] = (NW'(WIDTH - 1 - i) < n_sat);
      rng_mask[i] = (NW'(i) >= lo) && (NW'(i) <= hi);
    end

    mask_d  = '0;
    count_d = '0;
    unique case (s1_mode_q)
      ModeLsb: begin
        mask_d  = lsb_mask;
        count_d = n_sat;
      end
      ModeMsb: begin
        mask_d  = msb_mask;
        count_d = n_sat;
      end
      ModeRange: begin
        mask_d  = rng_mask;
        count_d = rng_ok ? (hi - lo + NW'(1)) : '0;
      end
      ModeInv: begin
        mask_d  = ~lsb_mask;
        count_d = WidthN - n_sat;
      end
      default: begin
        mask_d  = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= ModeLsb;
      s1_n_q     <= '0;
      s1_m_q     <= '0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= io.valid_i;
      if (io.valid_i) begin
        s1_mode_q <= mode_e'(io.mode_i);
        s1_n_q    <= io.n_i;
        s1_m_q    <= io.m_i;
        s1_tag_q  <= io.tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_mask_q  <= '0;
      s2_count_q <= '0;
      s2_tag_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mask_q  <= mask_d;
        s2_count_q <= count_d;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign io.valid_o = s2_valid_q;
  assign io.mask_o  = s2_mask_q;
  assign io.count_o = s2_count_q;
  assign io.tag_o   = s2_tag_q;

`ifndef SYNTHESIS
  // A stalled result must not change until the consumer takes it.
  a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (io.valid_o && !io.ready_i) |=>
      (io.valid_o && $stable(io.mask_o) && $stable(io.count_o) && $stable(io.tag_o)));
`endif

endmodule
